// File: rtl/anti_theft_fsm.sv
// Vehicle anti-theft controller: arm/trigger/alarm sequencing driven by doors,
// ignition and a 1 Hz countdown, with registered LED, siren and state outputs.
module anti_theft_fsm #(
    parameter int T_ARM_DELAY       = 6,
    parameter int T_DRIVER_DELAY    = 8,
    parameter int T_PASSENGER_DELAY = 15,
    parameter int T_ALARM_ON        = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       one_hz_enable,
    input  logic       ignition,
    input  logic       door_driver,
    input  logic       door_pass,
    input  logic       reprogram,
    output logic       status_led,
    output logic       siren,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ARMED      = 3'b000,
        TRIGGER    = 3'b001,
        ALARM      = 3'b010,
        DISARMED   = 3'b011,
        WAIT_OPEN  = 3'b100,
        WAIT_CLOSE = 3'b101,
        ARM_DELAY  = 3'b110
    } state_t;

    localparam logic [3:0] LD_ARM   = 4'(T_ARM_DELAY);
    localparam logic [3:0] LD_DRV   = 4'(T_DRIVER_DELAY);
    localparam logic [3:0] LD_PASS  = 4'(T_PASSENGER_DELAY);
    localparam logic [3:0] LD_ALARM = 4'(T_ALARM_ON);

    state_t     state_q, state_d;
    logic [3:0] timer_q, timer_d;
    logic       led_d, siren_d;
    logic       expire;

    // Expiry fires on the tick that would take the timer from 1 to 0.
    assign expire = one_hz_enable && (timer_q == 4'd1);
    assign state  = state_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ARMED;
            timer_q    <= 4'd0;
            status_led <= 1'b0;
            siren      <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            status_led <= led_d;
            siren      <= siren_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = (one_hz_enable && timer_q != 4'd0) ? timer_q - 4'd1 : timer_q;

        if (reprogram) begin
            state_d = ARMED;
            timer_d = 4'd0;
        end else begin
            case (state_q)
                ARMED: begin
                    if (door_driver) begin
                        state_d = TRIGGER;
                        timer_d = LD_DRV;
                    end else if (door_pass) begin
                        state_d = TRIGGER;
                        timer_d = LD_PASS;
                    end
                end
                TRIGGER: begin
                    if (ignition) begin
                        state_d = DISARMED;
                        timer_d = 4'd0;
                    end else if (expire) begin
                        // Siren hold time starts counting from alarm entry.
                        state_d = ALARM;
                        timer_d = LD_ALARM;
                    end
                end
                ALARM: begin
                    if (ignition) begin
                        state_d = DISARMED;
                        timer_d = 4'd0;
                    end else if (door_driver || door_pass) begin
                        timer_d = LD_ALARM;
                    end else if (expire) begin
                        state_d = ARMED;
                    end
                end
                DISARMED: begin
                    timer_d = 4'd0;
                    if (!ignition) state_d = WAIT_OPEN;
                end
                WAIT_OPEN: begin
                    if (ignition) begin
                        state_d = DISARMED;
                        timer_d = 4'd0;
                    end else if (door_driver) begin
                        state_d = WAIT_CLOSE;
                    end
                end
                WAIT_CLOSE: begin
                    if (ignition) begin
                        state_d = DISARMED;
                        timer_d = 4'd0;
                    end else if (!door_driver) begin
                        state_d = ARM_DELAY;
                        timer_d = LD_ARM;
                    end
                end
                ARM_DELAY: begin
                    if (ignition) begin
                        state_d = DISARMED;
                        timer_d = 4'd0;
                    end else if (door_driver) begin
                        state_d = WAIT_CLOSE;
                    end else if (expire) begin
                        state_d = ARMED;
                    end
                end
                default: begin
                    state_d = ARMED;
                    timer_d = 4'd0;
                end
            endcase
        end
    end

    // Outputs are computed from the next state so they register with it.
    always_comb begin
        siren_d = (state_d == ALARM);
        case (state_d)
            ARMED:          led_d = (state_q == ARMED) ? (status_led ^ one_hz_enable) : 1'b0;
            TRIGGER, ALARM: led_d = 1'b1;
            default:        led_d = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_anti_theft_fsm.sv
// Directed testbench for anti_theft_fsm with default timing parameters.
module tb_anti_theft_fsm;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       one_hz_enable = 1'b0;
    logic       ignition = 1'b0;
    logic       door_driver = 1'b0;
    logic       door_pass = 1'b0;
    logic       reprogram = 1'b0;
    logic       status_led;
    logic       siren;
    logic [2:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [2:0] S_ARMED = 3'd0, S_TRIG = 3'd1, S_ALARM = 3'd2,
                           S_DIS = 3'd3, S_WOPEN = 3'd4, S_WCLOSE = 3'd5, S_ADLY = 3'd6;

    anti_theft_fsm dut (
        .clock         (clock),
        .reset         (reset),
        .one_hz_enable (one_hz_enable),
        .ignition      (ignition),
        .door_driver   (door_driver),
        .door_pass     (door_pass),
        .reprogram     (reprogram),
        .status_led    (status_led),
        .siren         (siren),
        .state         (state)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock with the tick input as given; returns 1 time unit after the edge.
    task automatic cyc(input logic tick);
        one_hz_enable = tick;
        @(posedge clock);
        #1;
        one_hz_enable = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1);
    endtask

    initial begin
        // Reset state, before any clock edge
        #2;
        check("rst_state", state, S_ARMED);
        check("rst_siren", siren, 0);
        check("rst_led", status_led, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // LED toggles on ticks while armed
        cyc(1'b1);
        check("led_tog1", status_led, 1);
        cyc(1'b0);
        check("led_hold", status_led, 1);
        cyc(1'b1);
        check("led_tog2", status_led, 0);
        check("armed_stay", state, S_ARMED);

        // Ignition alone ignored while armed
        ignition = 1'b1;
        cyc(1'b0);
        check("armed_ign", state, S_ARMED);
        ignition = 1'b0;

        // Driver door pulse -> trigger, alarm on 8th tick
        door_driver = 1'b1;
        cyc(1'b0);
        door_driver = 1'b0;
        check("drv_trig", state, S_TRIG);
        check("drv_trig_led", status_led, 1);
        ticks(7);
        check("drv_7ticks", state, S_TRIG);
        check("drv_7siren", siren, 0);
        cyc(1'b1);
        check("drv_alarm", state, S_ALARM);
        check("drv_siren", siren, 1);

        // Alarm with doors closed: 10 ticks back to armed
        ticks(9);
        check("alm_9ticks", state, S_ALARM);
        cyc(1'b1);
        check("alm_armed", state, S_ARMED);
        check("alm_siren0", siren, 0);
        check("alm_led0", status_led, 0);

        // Alarm with door held 20 ticks, then 10 ticks after close
        door_driver = 1'b1;
        cyc(1'b0);
        ticks(8);
        check("hold_alarm", state, S_ALARM);
        ticks(20);
        check("hold_20", state, S_ALARM);
        check("hold_siren", siren, 1);
        door_driver = 1'b0;
        ticks(9);
        check("hold_9after", siren, 1);
        cyc(1'b1);
        check("hold_armed", state, S_ARMED);
        check("hold_siren0", siren, 0);

        // Passenger door then ignition after 3 ticks -> disarmed
        door_pass = 1'b1;
        cyc(1'b0);
        check("pass_trig", state, S_TRIG);
        ticks(3);
        check("pass_3siren", siren, 0);
        ignition = 1'b1;
        cyc(1'b0);
        check("pass_dis", state, S_DIS);
        check("pass_siren", siren, 0);
        check("pass_led", status_led, 0);
        door_pass = 1'b0;

        // Passenger delay is 15 ticks (from armed, door_pass only)
        reprogram = 1'b1;
        cyc(1'b0);
        check("reprog_dis", state, S_ARMED);
        reprogram = 1'b0;
        ignition = 1'b0;
        door_pass = 1'b1;
        cyc(1'b0);
        door_pass = 1'b0;
        ticks(14);
        check("pass_14", state, S_TRIG);
        cyc(1'b1);
        check("pass_15", state, S_ALARM);

        // Ignition disarms from alarm
        ignition = 1'b1;
        cyc(1'b0);
        check("alm_ign", state, S_DIS);
        check("alm_ign_sir", siren, 0);

        // Arming sequence with reopen at tick 4
        ignition = 1'b0;
        cyc(1'b0);
        check("wopen", state, S_WOPEN);
        door_driver = 1'b1;
        cyc(1'b0);
        check("wclose", state, S_WCLOSE);
        door_driver = 1'b0;
        cyc(1'b0);
        check("adly", state, S_ADLY);
        ticks(3);
        check("adly_3", state, S_ADLY);
        door_driver = 1'b1;
        cyc(1'b1);
        check("adly_reopen", state, S_WCLOSE);
        door_driver = 1'b0;
        cyc(1'b0);
        check("adly2", state, S_ADLY);
        ticks(5);
        check("adly2_5", state, S_ADLY);
        cyc(1'b1);
        check("adly2_armed", state, S_ARMED);

        // Both doors with coincident tick -> trigger with driver delay 8
        door_driver = 1'b1;
        door_pass = 1'b1;
        cyc(1'b1);
        check("both_trig", state, S_TRIG);
        door_driver = 1'b0;
        door_pass = 1'b0;
        ticks(7);
        check("both_7", state, S_TRIG);
        cyc(1'b1);
        check("both_8", state, S_ALARM);

        // Reprogram beats ignition
        reprogram = 1'b1;
        ignition = 1'b1;
        cyc(1'b0);
        check("reprog_pri", state, S_ARMED);
        check("reprog_sir", siren, 0);
        reprogram = 1'b0;
        ignition = 1'b0;

        // Asynchronous reset mid-alarm, between edges
        door_driver = 1'b1;
        cyc(1'b0);
        door_driver = 1'b0;
        ticks(8);
        check("ar_alarm", siren, 1);
        #2;
        reset = 1'b1;
        #1;
        check("ar_state", state, S_ARMED);
        check("ar_siren", siren, 0);
        check("ar_led", status_led, 0);
        reset = 1'b0;
        cyc(1'b1);
        check("ar_resume", state, S_ARMED);
        door_driver = 1'b1;
        cyc(1'b0);
        door_driver = 1'b0;
        check("ar_trig", state, S_TRIG);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
